// File: rtl/tile_bram_arbiter_if.sv
// ----------------------------------------------------------------------------
// tile_bram_arbiter_if
// Bundles every non-clock signal of the tile BRAM arbiter.
//   read side : rd_req_in, rd_addr_in (4x17 packed), rd_valid_out, rd_data_out
//   write side: wr_valid_in, wr_ready_out, wr_tile_in, wr_addr_in, wr_data_in
//   BRAM side : bram_addr_out, bram_we_out, bram_din_out, bram_dout_in
//   status    : fifo_level_out, err_addr_out, rd_conflict_out, clr_err_in
// slave  = the arbiter's view, master = the view of whoever drives it.
// ----------------------------------------------------------------------------
interface tile_bram_arbiter_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]        rd_req_in;
    logic [67:0]       rd_addr_in;
    logic [3:0]        rd_valid_out;
    logic [DATA_W-1:0] rd_data_out;
    logic              wr_valid_in;
    logic              wr_ready_out;
    logic [1:0]        wr_tile_in;
    logic [16:0]       wr_addr_in;
    logic [DATA_W-1:0] wr_data_in;
    logic [18:0]       bram_addr_out;
    logic              bram_we_out;
    logic [DATA_W-1:0] bram_din_out;
    logic [DATA_W-1:0] bram_dout_in;
    logic [LVL_W-1:0]  fifo_level_out;
    logic              err_addr_out;
    logic              rd_conflict_out;
    logic              clr_err_in;

    modport slave (
        input  rd_req_in, rd_addr_in, wr_valid_in, wr_tile_in, wr_addr_in,
               wr_data_in, bram_dout_in, clr_err_in,
        output rd_valid_out, rd_data_out, wr_ready_out, bram_addr_out,
               bram_we_out, bram_din_out, fifo_level_out, err_addr_out,
               rd_conflict_out
    );

    modport master (
        output rd_req_in, rd_addr_in, wr_valid_in, wr_tile_in, wr_addr_in,
               wr_data_in, bram_dout_in, clr_err_in,
        input  rd_valid_out, rd_data_out, wr_ready_out, bram_addr_out,
               bram_we_out, bram_din_out, fifo_level_out, err_addr_out,
               rd_conflict_out
    );
endinterface

// File: rtl/tile_bram_arbiter.sv
// ----------------------------------------------------------------------------
// tile_bram_arbiter
// Shares one single-port frame BRAM (four 240x320 tiles back to back) between
// four display readers and one buffered writer. Reads always win the port;
// writes wait in a FIFO and drain in cycles with no read request.
// Ports:
//   clk_in   : pixel clock
//   rst_n_in : asynchronous active-low reset
//   bus      : tile_bram_arbiter_if.slave (read/write/BRAM/status signals)
// ----------------------------------------------------------------------------
module tile_bram_arbiter #(
    parameter int FIFO_DEPTH   = 16,
    parameter int BRAM_LATENCY = 2,
    parameter int DATA_W       = 8,
    parameter int TILE_PIXELS  = 76800
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    tile_bram_arbiter_if.slave   bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int PIPE_N = 1 + BRAM_LATENCY;   // request cycle -> data cycle
    localparam logic [16:0] TILE_LIMIT  = 17'(TILE_PIXELS);
    localparam logic [18:0] TILE_STRIDE = 19'(TILE_PIXELS);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Constant multiply-add: tile base plus tile-local offset.
    function automatic logic [18:0] phys_addr(input logic [1:0] tile, input logic [16:0] addr);
        phys_addr = 19'(tile) * TILE_STRIDE + {2'b00, addr};
    endfunction

    function automatic logic addr_in_range(input logic [16:0] addr);
        addr_in_range = (addr < TILE_LIMIT);
    endfunction

    // FIFO storage and control
    logic [1:0]        r_fifo_tile [FIFO_DEPTH];
    logic [16:0]       r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_count;
    logic              r_wr_ready;

    // BRAM port and status registers
    logic [18:0]       r_bram_addr;
    logic              r_bram_we;
    logic [DATA_W-1:0] r_bram_din;
    logic              r_err_addr;
    logic              r_rd_conflict;

    // Read return pipeline: one-hot tile tag and "address was legal" per stage
    logic [PIPE_N-1:0][3:0] r_pipe_vld;
    logic [PIPE_N-1:0]      r_pipe_ok;

    logic [1:0]        w_grant_idx;
    logic [16:0]       w_rd_addr;
    logic              w_grant_any;
    logic [3:0]        w_grant_oh;
    logic              w_conflict;
    logic              w_rd_ok;
    logic              w_push;
    logic              w_pop;
    logic              w_head_ok;
    logic              w_err_new;
    logic [LVL_W-1:0]  w_count_next;
    logic [1:0]        w_head_tile;
    logic [16:0]       w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    // Lowest-index requester wins; pick its address slice.
    always_comb begin
        w_grant_idx = 2'd0;
        w_rd_addr   = 17'd0;
        casez (bus.rd_req_in)
            4'b???1: begin w_grant_idx = 2'd0; w_rd_addr = bus.rd_addr_in[16:0];  end
            4'b??10: begin w_grant_idx = 2'd1; w_rd_addr = bus.rd_addr_in[33:17]; end
            4'b?100: begin w_grant_idx = 2'd2; w_rd_addr = bus.rd_addr_in[50:34]; end
            4'b1000: begin w_grant_idx = 2'd3; w_rd_addr = bus.rd_addr_in[67:51]; end
            default: begin w_grant_idx = 2'd0; w_rd_addr = 17'd0;                 end
        endcase
    end

    assign w_grant_any = |bus.rd_req_in;
    // x & -x isolates the lowest set bit, i.e. the one-hot grant.
    assign w_grant_oh  = bus.rd_req_in & (~bus.rd_req_in + 4'd1);
    assign w_conflict  = (bus.rd_req_in & (bus.rd_req_in - 4'd1)) != 4'd0;
    assign w_rd_ok     = w_grant_any && addr_in_range(w_rd_addr);

    assign w_head_tile = r_fifo_tile[r_rd_ptr];
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_ok   = addr_in_range(w_head_addr);

    // wr_ready is registered, so a pop never frees space in its own cycle.
    assign w_push    = bus.wr_valid_in && r_wr_ready;
    assign w_pop     = !w_grant_any && (r_count != {LVL_W{1'b0}});
    assign w_err_new = (w_grant_any && !w_rd_ok) || (w_pop && !w_head_ok);

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + LVL_W'(1);
            2'b01:   w_count_next = r_count - LVL_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO entry storage.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_tile[i] <= 2'd0;
                r_fifo_addr[i] <= 17'd0;
                r_fifo_data[i] <= {DATA_W{1'b0}};
            end
        end else if (w_push) begin
            r_fifo_tile[r_wr_ptr] <= bus.wr_tile_in;
            r_fifo_addr[r_wr_ptr] <= bus.wr_addr_in;
            r_fifo_data[r_wr_ptr] <= bus.wr_data_in;
        end
    end

    // FIFO pointers (wrap modulo depth), occupancy and registered ready.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {LVL_W{1'b0}};
            r_wr_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_wr_ready <= (w_count_next != LVL_FULL);
        end
    end

    // BRAM port: a legal read takes the port; otherwise a legal drained write.
    // Illegal addresses never touch the BRAM.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bram_addr <= 19'd0;
            r_bram_we   <= 1'b0;
            r_bram_din  <= {DATA_W{1'b0}};
        end else if (w_rd_ok) begin
            r_bram_addr <= phys_addr(w_grant_idx, w_rd_addr);
            r_bram_we   <= 1'b0;
        end else if (w_pop && w_head_ok) begin
            r_bram_addr <= phys_addr(w_head_tile, w_head_addr);
            r_bram_we   <= 1'b1;
            r_bram_din  <= w_head_data;
        end else begin
            r_bram_we   <= 1'b0;
        end
    end

    // Read return tags, aligned with BRAM output data.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pipe_vld <= '0;
            r_pipe_ok  <= '0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[PIPE_N-2:0], w_grant_oh};
            r_pipe_ok  <= {r_pipe_ok[PIPE_N-2:0], w_rd_ok};
        end
    end

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_err_addr    <= 1'b0;
            r_rd_conflict <= 1'b0;
        end else begin
            if (w_err_new)            r_err_addr <= 1'b1;
            else if (bus.clr_err_in)  r_err_addr <= 1'b0;
            if (w_conflict)           r_rd_conflict <= 1'b1;
            else if (bus.clr_err_in)  r_rd_conflict <= 1'b0;
        end
    end

    assign bus.rd_valid_out    = r_pipe_vld[PIPE_N-1];
    // Read data arrives straight from the BRAM in the return cycle; it is
    // gated by the registered tag so it is 0 for illegal reads and in reset.
    assign bus.rd_data_out     = r_pipe_ok[PIPE_N-1] ? bus.bram_dout_in : {DATA_W{1'b0}};
    assign bus.wr_ready_out    = r_wr_ready;
    assign bus.bram_addr_out   = r_bram_addr;
    assign bus.bram_we_out     = r_bram_we;
    assign bus.bram_din_out    = r_bram_din;
    assign bus.fifo_level_out  = r_count;
    assign bus.err_addr_out    = r_err_addr;
    assign bus.rd_conflict_out = r_rd_conflict;
endmodule

// File: tb/tb_tile_bram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tile_bram_arbiter
// Directed bench for tile_bram_arbiter with a 2-cycle-latency BRAM model whose
// read data is (address low byte) ^ 8'hA5.
// ----------------------------------------------------------------------------
module tb_tile_bram_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] r_d1;
    logic [7:0] r_d2;

    tile_bram_arbiter_if #(.DATA_W(8), .FIFO_DEPTH(16)) bus ();

    tile_bram_arbiter #(
        .FIFO_DEPTH(16), .BRAM_LATENCY(2), .DATA_W(8), .TILE_PIXELS(76800)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: data for the address of cycle c appears in cycle c+2.
    always @(posedge clk) begin
        r_d1 <= bus.bram_addr_out[7:0] ^ 8'hA5;
        r_d2 <= r_d1;
    end
    assign bus.bram_dout_in = r_d2;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.rd_req_in   = 4'd0;
        bus.rd_addr_in  = 68'd0;
        bus.wr_valid_in = 1'b0;
        bus.wr_tile_in  = 2'd0;
        bus.wr_addr_in  = 17'd0;
        bus.wr_data_in  = 8'd0;
        bus.clr_err_in  = 1'b0;

        // Reset state
        #12;
        check("rst_ready",   32'(bus.wr_ready_out),   32'd0);
        check("rst_level",   32'(bus.fifo_level_out), 32'd0);
        check("rst_we",      32'(bus.bram_we_out),    32'd0);
        check("rst_addr",    32'(bus.bram_addr_out),  32'd0);
        check("rst_rvalid",  32'(bus.rd_valid_out),   32'd0);
        check("rst_rdata",   32'(bus.rd_data_out),    32'd0);
        check("rst_err",     32'(bus.err_addr_out),   32'd0);
        check("rst_conf",    32'(bus.rd_conflict_out),32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre", 32'(bus.wr_ready_out), 32'd0);
        tick();
        check("rel_ready",   32'(bus.wr_ready_out),   32'd1);
        check("rel_level",   32'(bus.fifo_level_out), 32'd0);

        // Single read: tile 2, addr 5
        bus.rd_req_in = 4'b0100;
        bus.rd_addr_in[50:34] = 17'd5;
        tick();
        bus.rd_req_in = 4'b0000;
        check("rd_addr",     32'(bus.bram_addr_out), 32'd153605);
        check("rd_we0",      32'(bus.bram_we_out),   32'd0);
        check("rd_vld_c1",   32'(bus.rd_valid_out),  32'd0);
        tick();
        check("rd_vld_c2",   32'(bus.rd_valid_out),  32'd0);
        tick();
        check("rd_vld_c3",   32'(bus.rd_valid_out),  32'h4);
        check("rd_data_c3",  32'(bus.rd_data_out),   32'hA0);
        tick();
        check("rd_vld_c4",   32'(bus.rd_valid_out),  32'd0);
        check("rd_noconf",   32'(bus.rd_conflict_out), 32'd0);

        // Conflict: tiles 0 and 1 together, tile 0 wins
        bus.rd_req_in = 4'b0011;
        bus.rd_addr_in[16:0]  = 17'd100;
        bus.rd_addr_in[33:17] = 17'd200;
        tick();
        bus.rd_req_in = 4'b0000;
        check("conf_addr",   32'(bus.bram_addr_out),   32'd100);
        check("conf_flag",   32'(bus.rd_conflict_out), 32'd1);
        tick();
        tick();
        check("conf_vld",    32'(bus.rd_valid_out),  32'h1);
        check("conf_data",   32'(bus.rd_data_out),   32'hC1);
        bus.clr_err_in = 1'b1;
        tick();
        bus.clr_err_in = 1'b0;
        check("conf_clr",    32'(bus.rd_conflict_out), 32'd0);

        // Back-to-back reads on tile 1 give a continuous valid stream
        bus.rd_req_in = 4'b0010;
        bus.rd_addr_in[33:17] = 17'd1;
        tick();
        bus.rd_addr_in[33:17] = 17'd2;
        tick();
        bus.rd_addr_in[33:17] = 17'd3;
        tick();
        bus.rd_req_in = 4'b0000;
        check("b2b_vld0",  32'(bus.rd_valid_out), 32'h2);
        check("b2b_dat0",  32'(bus.rd_data_out),  32'hA4);
        tick();
        check("b2b_vld1",  32'(bus.rd_valid_out), 32'h2);
        check("b2b_dat1",  32'(bus.rd_data_out),  32'hA7);
        tick();
        check("b2b_vld2",  32'(bus.rd_valid_out), 32'h2);
        check("b2b_dat2",  32'(bus.rd_data_out),  32'hA6);
        tick();
        check("b2b_end",   32'(bus.rd_valid_out), 32'd0);

        // Fill the FIFO while reads hold the port
        bus.rd_req_in = 4'b0001;
        bus.rd_addr_in[16:0] = 17'd0;
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid_in = 1'b1;
            bus.wr_tile_in  = 2'd1;
            bus.wr_addr_in  = 17'(i);
            bus.wr_data_in  = 8'h10 + 8'(i);
            tick();
        end
        bus.wr_valid_in = 1'b0;
        check("full_level", 32'(bus.fifo_level_out), 32'd16);
        check("full_ready", 32'(bus.wr_ready_out),   32'd0);
        check("full_nowe",  32'(bus.bram_we_out),    32'd0);
        // Push attempt while full is refused
        bus.wr_valid_in = 1'b1;
        bus.wr_data_in  = 8'hFF;
        tick();
        bus.wr_valid_in = 1'b0;
        check("full_hold",  32'(bus.fifo_level_out), 32'd16);
        // Release reads: 16 writes drain in order
        bus.rd_req_in = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_we",   32'(bus.bram_we_out),   32'd1);
            check("drain_addr", 32'(bus.bram_addr_out), 32'd76800 + 32'(i));
            check("drain_din",  32'(bus.bram_din_out),  32'h10 + 32'(i));
        end
        check("drain_ready", 32'(bus.wr_ready_out),   32'd1);
        check("drain_level", 32'(bus.fifo_level_out), 32'd0);
        tick();
        check("drain_done",  32'(bus.bram_we_out),    32'd0);

        // Last legal pixel of tile 3
        bus.wr_valid_in = 1'b1;
        bus.wr_tile_in  = 2'd3;
        bus.wr_addr_in  = 17'd76799;
        bus.wr_data_in  = 8'h5A;
        tick();
        bus.wr_valid_in = 1'b0;
        check("max_level",  32'(bus.fifo_level_out), 32'd1);
        check("max_we_c1",  32'(bus.bram_we_out),    32'd0);
        tick();
        check("max_we",     32'(bus.bram_we_out),    32'd1);
        check("max_addr",   32'(bus.bram_addr_out),  32'd307199);
        check("max_din",    32'(bus.bram_din_out),   32'h5A);
        check("max_err",    32'(bus.err_addr_out),   32'd0);

        // Illegal write address is accepted then dropped
        bus.wr_valid_in = 1'b1;
        bus.wr_tile_in  = 2'd0;
        bus.wr_addr_in  = 17'd76800;
        bus.wr_data_in  = 8'h33;
        tick();
        bus.wr_valid_in = 1'b0;
        check("bad_wr_level", 32'(bus.fifo_level_out), 32'd1);
        tick();
        check("bad_wr_we",    32'(bus.bram_we_out),    32'd0);
        check("bad_wr_err",   32'(bus.err_addr_out),   32'd1);
        check("bad_wr_lvl0",  32'(bus.fifo_level_out), 32'd0);

        // Illegal read with clear in the same cycle: error wins, data 0
        bus.rd_req_in = 4'b0001;
        bus.rd_addr_in[16:0] = 17'd76800;
        bus.clr_err_in = 1'b1;
        tick();
        bus.rd_req_in  = 4'b0000;
        bus.clr_err_in = 1'b0;
        check("bad_rd_err",  32'(bus.err_addr_out),  32'd1);
        check("bad_rd_addr", 32'(bus.bram_addr_out), 32'd307199);
        tick();
        tick();
        check("bad_rd_vld",  32'(bus.rd_valid_out),  32'h1);
        check("bad_rd_data", 32'(bus.rd_data_out),   32'd0);
        bus.clr_err_in = 1'b1;
        tick();
        bus.clr_err_in = 1'b0;
        check("err_clr",     32'(bus.err_addr_out),  32'd0);

        // Reset with 8 buffered writes and reads in flight
        bus.rd_req_in = 4'b0001;
        bus.rd_addr_in[16:0] = 17'd7;
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid_in = 1'b1;
            bus.wr_tile_in  = 2'd2;
            bus.wr_addr_in  = 17'(i);
            bus.wr_data_in  = 8'(i);
            tick();
        end
        bus.wr_valid_in = 1'b0;
        check("mid_level",  32'(bus.fifo_level_out), 32'd8);
        check("mid_vld",    32'(bus.rd_valid_out),   32'h1);
        rst_n = 1'b0;
        bus.rd_req_in = 4'b0000;
        #1;
        check("mid_rst_vld",   32'(bus.rd_valid_out),   32'd0);
        check("mid_rst_data",  32'(bus.rd_data_out),    32'd0);
        check("mid_rst_level", 32'(bus.fifo_level_out), 32'd0);
        check("mid_rst_ready", 32'(bus.wr_ready_out),   32'd0);
        check("mid_rst_addr",  32'(bus.bram_addr_out),  32'd0);
        check("mid_rst_we",    32'(bus.bram_we_out),    32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_ready",  32'(bus.wr_ready_out),   32'd1);
        check("post_level",  32'(bus.fifo_level_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("post_vld", 32'(bus.rd_valid_out), 32'd0);
            check("post_we",  32'(bus.bram_we_out),  32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
